// File: rtl/fft64_result_streamer_if.sv
// fft64_result_streamer_if
// Serial bin stream from the FFT result streamer to a downstream consumer.
//
// Handshake: a beat transfers on every rising clk edge where out_valid and
// out_ready are both high. The master never lowers out_valid or changes the
// payload (out_real, out_imag, out_index, out_first, out_last) while
// out_valid is high and out_ready is low. out_valid does not depend
// combinationally on out_ready.
//
// Signals:
//   out_valid  master->slave  beat valid
//   out_ready  slave->master  consumer accepts beat
//   out_real   master->slave  real part of current bin (WIDTH)
//   out_imag   master->slave  imaginary part of current bin (WIDTH)
//   out_index  master->slave  bin number 0..63
//   out_first  master->slave  high on the bin 0 beat
//   out_last   master->slave  high on the bin 63 beat (FFT_STREAM_LAST_EN only)
//
// Optional macro: FFT_STREAM_LAST_EN adds out_last.
interface fft64_result_streamer_if #(
   parameter int WIDTH = 16
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_real;
   logic [WIDTH-1:0] out_imag;
   logic [5:0]       out_index;
   logic             out_first;
`ifdef FFT_STREAM_LAST_EN
   logic             out_last;

   modport master (
      output out_valid, out_real, out_imag, out_index, out_first, out_last,
      input  out_ready
   );
   modport slave (
      input  out_valid, out_real, out_imag, out_index, out_first, out_last,
      output out_ready
   );
`else
   modport master (
      output out_valid, out_real, out_imag, out_index, out_first,
      input  out_ready
   );
   modport slave (
      input  out_valid, out_real, out_imag, out_index, out_first,
      output out_ready
   );
`endif
endinterface

// File: rtl/fft64_result_streamer.sv
// fft64_result_streamer
// Captures the 8x8 complex DFT result matrix on the one-cycle done pulse and
// streams the 64 bins out in natural order (bin n = row n%8, col n/8) over a
// valid/ready handshake. The data path is a plain registered copy.
//
// Ports:
//   clk         system clock
//   sreset      synchronous active-high reset (wins over done)
//   done        one-cycle pulse: realfft/imagfft valid this cycle
//   realfft     real result matrix [row][col], WIDTH bits per element
//   imagfft     imaginary result matrix [row][col]
//   strm        stream interface (master modport), see fft64_result_streamer_if
//   busy        a frame is held and being streamed
//   overflow    one-cycle pulse when a done had to be dropped
//   drop_count  saturating count of dropped frames
//   state_dbg   current FSM state (0 = IDLE, 1 = STREAM)
//
// Optional macro: FFT_STREAM_LAST_EN adds strm.out_last (high on bin 63).
// WIDTH must match the WIDTH of the connected interface instance.
module fft64_result_streamer #(
   parameter int WIDTH      = 16,
   parameter int DROP_CNT_W = 8
) (
   input  logic                        clk,
   input  logic                        sreset,
   input  logic                        done,
   input  logic [7:0][7:0][WIDTH-1:0]  realfft,
   input  logic [7:0][7:0][WIDTH-1:0]  imagfft,
   fft64_result_streamer_if.master     strm,
   output logic                        busy,
   output logic                        overflow,
   output logic [DROP_CNT_W-1:0]       drop_count,
   output logic                        state_dbg
);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

   state_t                       state_q, state_d;
   logic [5:0]                   index_q, index_d;
   logic [7:0][7:0][WIDTH-1:0]   hold_re, hold_im;
   logic                         capture, drop, xfer;
   logic                         overflow_q;
   logic [DROP_CNT_W-1:0]        drop_q;

   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q    <= IDLE;
         index_q    <= 6'd0;
         hold_re    <= '0;
         hold_im    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         overflow_q <= drop;
         if (capture) begin
            hold_re <= realfft;
            hold_im <= imagfft;
         end
         if (drop && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_q <= drop_q + DROP_ONE;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      capture = 1'b0;
      drop    = 1'b0;
      xfer    = (state_q == STREAM) && strm.out_ready;
      case (state_q)
         IDLE: begin
            if (done) begin
               capture = 1'b1;
               index_d = 6'd0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (xfer) begin
               index_d = index_q + 6'd1;
               if (index_q == 6'd63) begin
                  // Last bin leaving: a coincident done starts the next
                  // frame with no bubble, otherwise go idle.
                  index_d = 6'd0;
                  if (done) capture = 1'b1;
                  else      state_d = IDLE;
               end
            end
            if (done && !(xfer && (index_q == 6'd63))) drop = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bin n sits at row n%8, col n/8: the column-major read of the matrix.
   assign strm.out_valid = (state_q == STREAM);
   assign strm.out_index = index_q;
   assign strm.out_real  = hold_re[index_q[2:0]][index_q[5:3]];
   assign strm.out_imag  = hold_im[index_q[2:0]][index_q[5:3]];
   assign strm.out_first = (state_q == STREAM) && (index_q == 6'd0);
`ifdef FFT_STREAM_LAST_EN
   assign strm.out_last  = (state_q == STREAM) && (index_q == 6'd63);
`endif

   assign busy       = (state_q == STREAM);
   assign overflow   = overflow_q;
   assign drop_count = drop_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fft64_result_streamer.sv
// Testbench for fft64_result_streamer: hand sequences, a probe table and
// randomized frames, all checked against a frame-level queue model.
module tb_fft64_result_streamer;

   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   sreset, done, ready;
   logic [7:0][7:0][W-1:0] realfft, imagfft;
   logic                   busy, overflow, state_dbg;
   logic [7:0]             drop_count;

   fft64_result_streamer_if #(.WIDTH(W)) s();
   assign s.out_ready = ready;

   fft64_result_streamer #(.WIDTH(W), .DROP_CNT_W(8)) dut (
      .clk(clk), .sreset(sreset), .done(done),
      .realfft(realfft), .imagfft(imagfft),
      .strm(s), .busy(busy), .overflow(overflow),
      .drop_count(drop_count), .state_dbg(state_dbg)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The held frame is a queue of remaining {real,imag} bins in stream order.
   logic [2*W-1:0] exp_q[$];
   int  m_idx = 0;
   bit  m_ovf = 0;
   int  m_drops = 0;
   bit  m_was, m_xf, m_last;
   bit  mon_en = 0;

   always @(posedge clk) begin
      if (sreset) begin
         exp_q.delete();
         m_idx = 0; m_ovf = 0; m_drops = 0;
      end else begin
         m_was  = exp_q.size() > 0;
         m_xf   = m_was && ready;
         m_last = m_xf && (exp_q.size() == 1);
         m_ovf  = 0;
         if (m_xf) begin
            void'(exp_q.pop_front());
            m_idx++;
         end
         if (done) begin
            if (!m_was || m_last) begin
               exp_q.delete();
               for (int n = 0; n < 64; n++)
                  exp_q.push_back({realfft[n % 8][n / 8], imagfft[n % 8][n / 8]});
               m_idx = 0;
            end else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("valid", s.out_valid, exp_q.size() > 0);
         chk("busy", busy, exp_q.size() > 0);
         chk("overflow", overflow, m_ovf);
         chk("drop_count", drop_count, m_drops);
         if (exp_q.size() > 0) begin
            chk("index", s.out_index, m_idx);
            chk("real", s.out_real, exp_q[0][2*W-1:W]);
            chk("imag", s.out_imag, exp_q[0][W-1:0]);
            chk("first", s.out_first, m_idx == 0);
`ifdef FFT_STREAM_LAST_EN
            chk("last", s.out_last, m_idx == 63);
`endif
         end
`ifdef FFT_STREAM_LAST_EN
         else chk("last_idle", s.out_last, 1'b0);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_basic();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            realfft[r][c] = W'(16 * r + c);
            imagfft[r][c] = ~W'(16 * r + c);
         end
   endtask

   task automatic set_const(input logic [W-1:0] v);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            realfft[r][c] = v;
            imagfft[r][c] = v;
         end
   endtask

   task automatic set_rand();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            realfft[r][c] = W'($urandom);
            imagfft[r][c] = W'($urandom);
         end
   endtask

   task automatic pulse_done();
      done = 1'b1;
      step();
      done = 1'b0;
   endtask

   task automatic drain();
      int g;
      ready = 1'b1;
      done  = 1'b0;
      g = 0;
      while (s.out_valid && g < 300) begin
         step();
         g++;
      end
      if (s.out_valid) chk("drain_timeout", 1'b1, 1'b0);
   endtask

   typedef struct {
      int r;
      int c;
      int exp_n;
   } probe_t;

   probe_t probes[8];

   initial begin
      int beats, guard, stall, found;
      bit tog;

      probes[0] = '{0, 0, 0};
      probes[1] = '{1, 0, 1};
      probes[2] = '{7, 0, 7};
      probes[3] = '{0, 1, 8};
      probes[4] = '{3, 5, 43};
      probes[5] = '{6, 2, 22};
      probes[6] = '{0, 7, 56};
      probes[7] = '{7, 7, 63};

      sreset = 1'b1; done = 1'b0; ready = 1'b0;
      realfft = '0; imagfft = '0;
      step();
      mon_en = 1;
      step();
      sreset = 1'b0;

      // reset state
      chk("rst_valid", s.out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_drop", drop_count, 8'd0);
      chk("rst_real", s.out_real, 16'd0);
      chk("rst_index", s.out_index, 6'd0);
      chk("rst_first", s.out_first, 1'b0);

      // basic frame
      set_basic();
      ready = 1'b1;
      pulse_done();
      chk("basic_latency", s.out_valid, 1'b1);
      beats = 0; guard = 0;
      while (s.out_valid && guard < 200) begin
         chk("basic_real", s.out_real, 16 * (beats % 8) + beats / 8);
         chk("basic_first", s.out_first, beats == 0);
         beats++;
         step();
         guard++;
      end
      chk("basic_beats", beats, 64);
      chk("basic_busy_end", busy, 1'b0);

      // backpressure: alternate ready, plus a 5-cycle stall at index 10
      set_basic();
      ready = 1'b1;
      pulse_done();
      beats = 0; guard = 0; stall = 0; tog = 1'b0;
      while (s.out_valid && guard < 400) begin
         if (s.out_index == 6'd10 && stall < 5) begin
            ready = 1'b0;
            stall++;
         end else begin
            tog   = ~tog;
            ready = tog;
         end
         if (ready) beats++;
         step();
         guard++;
      end
      chk("bp_beats", beats, 64);
      chk("bp_stall", stall, 5);

      // back-to-back frames
      set_basic();
      ready = 1'b1;
      pulse_done();
      repeat (63) step();
      chk("b2b_idx63", s.out_index, 6'd63);
      set_const(16'h1234);
      pulse_done();
      chk("b2b_valid", s.out_valid, 1'b1);
      chk("b2b_first", s.out_first, 1'b1);
      chk("b2b_real", s.out_real, 16'h1234);
      chk("b2b_index", s.out_index, 6'd0);
      chk("b2b_overflow", overflow, 1'b0);
      drain();

      // overflow at index 20
      set_basic();
      ready = 1'b1;
      pulse_done();
      repeat (20) step();
      chk("ovf_idx20", s.out_index, 6'd20);
      set_const(16'hFFFF);
      pulse_done();
      chk("ovf_pulse", overflow, 1'b1);
      chk("ovf_count", drop_count, 8'd1);
      chk("ovf_keep_real", s.out_real, 16 * (21 % 8) + 21 / 8);
      step();
      chk("ovf_one_cycle", overflow, 1'b0);
      drain();

      // 300 drops saturate the counter
      set_basic();
      pulse_done();
      ready = 1'b0;
      repeat (300) begin
         done = 1'b1;
         step();
         done = 1'b0;
         step();
      end
      chk("ovf_saturate", drop_count, 8'd255);
      drain();

      // reset mid-stream
      set_basic();
      ready = 1'b1;
      pulse_done();
      repeat (30) step();
      chk("rstm_idx30", s.out_index, 6'd30);
      sreset = 1'b1;
      step();
      sreset = 1'b0;
      chk("rstm_valid", s.out_valid, 1'b0);
      chk("rstm_busy", busy, 1'b0);
      chk("rstm_drop", drop_count, 8'd0);
      pulse_done();
      chk("rstm_restart_valid", s.out_valid, 1'b1);
      chk("rstm_restart_index", s.out_index, 6'd0);
      drain();

      // reset and done on the same edge: nothing captured
      sreset = 1'b1; done = 1'b1;
      step();
      sreset = 1'b0; done = 1'b0;
      chk("rst_done_valid", s.out_valid, 1'b0);

      // bin-mapping probe table
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_const(16'h0000);
         realfft[probes[i].r][probes[i].c] = 16'hABCD;
         pulse_done();
         found = -1;
         for (int n = 0; n < 64; n++) begin
            if (s.out_real == 16'hABCD) found = int'(s.out_index);
            step();
         end
         chk("probe_bin", found, probes[i].exp_n);
         drain();
      end

      // randomized frames, ready and done
      repeat (4) begin
         set_rand();
         pulse_done();
         repeat (150) begin
            ready = 1'($urandom_range(0, 1));
            done  = ($urandom_range(0, 15) == 0);
            if (done) set_rand();
            step();
         end
         done = 1'b0;
         drain();
      end

      step();
      mon_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft64_result_streamer.md
Name: fft64_result_streamer

Overview:
Consumer end of the 64-point DFT result interface. It captures the 8x8 complex result matrix (real and imaginary) on the one-cycle done pulse and streams the 64 bins out one per beat over a valid/ready handshake, in natural bin order. It sits between the dft64 result matrix and any serial downstream consumer, such as a magnitude unit, UART, or FIFO. It decouples the parallel result from the consumer's rate.

Parameters:
WIDTH, 16, bit width of each real and imaginary component
DROP_CNT_W, 8, width of the saturating dropped-frame counter

Ports:
clk  input  1  system clock
sreset  input  1  synchronous active-high reset
done  input  1  one-cycle pulse: result matrix valid this cycle
realfft  input  8x8xWIDTH  real result matrix [row][col]
imagfft  input  8x8xWIDTH  imaginary result matrix [row][col]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_real  output  WIDTH  real part of the current bin
out_imag  output  WIDTH  imaginary part of the current bin
out_index  output  6  bin number 0..63 of the current beat
out_first  output  1  high on the bin 0 beat
busy  output  1  frame held (capture or streaming in progress)
overflow  output  1  one-cycle pulse when done arrives and cannot be accepted
drop_count  output  DROP_CNT_W  saturating count of dropped frames

Behaviour:
- Reset: all outputs are synchronous and reset to 0; out_valid=0, busy=0, overflow=0, drop_count=0; the internal buffer clears to 0; the state goes to IDLE. Reset mid-stream aborts the frame; out_valid is 0 on the cycle after the reset edge.
- States: IDLE and STREAM.
- IDLE: on an edge with done=1, latch all 128 words into the internal buffer, set index=0, and go to STREAM.
- Latency: done sampled at edge N gives out_valid=1 with bin 0 after edge N.
- STREAM: out_valid=1 and busy=1.
  - Bin mapping: out_index=n, row r=n%8, col c=n/8. out_real=buffer_real[r][c] and out_imag=buffer_imag[r][c]. Bin n=8*c+r is the column-major read of the matrix.
  - A beat transfers on an edge with out_valid&&out_ready; index then increments.
  - While out_valid&&!out_ready, out_real, out_imag, out_index and out_first hold stable.
  - out_first=1 exactly when index==0.
- End of frame: after the beat at index 63 transfers, return to IDLE; out_valid=0 on the next cycle.
- done during STREAM:
  - If the same edge transfers index 63, the new frame is captured (back-to-back). State stays STREAM and index=0, with no bubble.
  - Otherwise the new frame is dropped and the held frame is unaffected. overflow pulses high for one cycle, and drop_count increments, saturating at all-ones.
- sreset and done together: reset wins and nothing is captured.
- The block does no arithmetic. The data path is a pure registered copy, so WIDTH bits pass unchanged (no sign handling).
- Registered outputs come from the buffer through the index mux. There is no combinational path from out_ready to out_valid.

Optional Feature:
FFT_STREAM_LAST_EN:
- Defined: adds output port out_last (1 bit), high when out_valid and index==63; reset value 0.
- Undefined: the port does not exist, and all other behaviour is identical.

Test Plan:
- Basic frame: load realfft[r][c]=16*r+c and imagfft=~real; pulse done with out_ready=1. Require out_valid 1 cycle later and 64 consecutive beats. Beat n must carry out_real=16*(n%8)+n/8, with out_first only on n=0. busy drops after beat 63.
- Backpressure: same frame, with out_ready toggling 1/0 on alternate cycles and held low for 5 cycles at index 10. Require data and index stable while stalled, no beat lost or duplicated, and 64 beats in total.
- Back-to-back: second done with a new matrix (all 0x1234) on the exact edge where beat 63 transfers. Require beat 0 of the new frame on the next cycle, out_first=1 and out_real=0x1234, overflow=0.
- Overflow: done at index 20. Require overflow pulse of 1 cycle, drop_count=1, and the remaining beats 20..63 from the original frame. Issue 300 such drops and require drop_count saturated at 255.
- Reset mid-stream: assert sreset at index 30. Require out_valid=0, busy=0 and drop_count=0 on the next cycle; a subsequent done restarts at index 0.
- With FFT_STREAM_LAST_EN: out_last=1 only on the index 63 beat in the basic and backpressure cases.
